ms_uart_tx_feeder: RTL and testbench
====================================

// Module: ms_uart_tx_feeder
// PURPOSE
//  Byte buffer and launch sequencer directly upstream of the UART transmitter.
//  The bus side pushes bytes into a FIFO. The block pops them one at a time and
//  presents each on TX_DIN with a held TX_START. It then tracks the
//  transmitter's BUSY/DONE handshake until the frame completes.
//  This decouples AHB write bursts from the slow, TICK-paced serial line.
// PARAMETERS
//  DEPTH        16      FIFO depth in bytes; power of two, >= 2
//  AW           4       log2(DEPTH); LEVEL is AW+1 bits wide
//  SYNC_STAGES  2       flops on TX_BUSY/TX_DONE before use; 0 = none
//  ARM_TIMEOUT  65535   CLK cycles to wait for TX_BUSY after raising TX_START
// PORTS
//  CLK        in   1     single clock; all logic on posedge
//  RESETN     in   1     asynchronous, active-low reset
//  EN         in   1     1 = launcher may start new frames; FIFO writes always allowed
//  FLUSH      in   1     1-cycle pulse: empty FIFO; an in-flight frame completes
//  WR_EN      in   1     push WR_DATA this cycle
//  WR_DATA    in   8     byte to transmit
//  OVF_CLR    in   1     clears OVERFLOW and ARM_ERR
//  FULL       out  1     LEVEL == DEPTH
//  EMPTY      out  1     LEVEL == 0
//  LEVEL      out  AW+1  bytes stored; excludes the byte in flight
//  OVERFLOW   out  1     sticky: a write was dropped while FULL
//  ARM_ERR    out  1     sticky: transmitter never acknowledged TX_START
//  IDLE       out  1     FIFO empty and launcher in S_IDLE
//  TX_START   out  1     to transmitter START
//  TX_DIN     out  8     to transmitter DIN
//  TX_BUSY    in   1     from transmitter BUSY
//  TX_DONE    in   1     from transmitter DONE
// BEHAVIOUR
//  Reset (async assert, sync deassert):
//   - FULL=0, EMPTY=1, LEVEL=0, OVERFLOW=0, ARM_ERR=0, IDLE=1, TX_START=0, TX_DIN=8'h00.
//   - Pointers and timer cleared; FSM = S_IDLE.
//   - Reset mid-frame drops TX_START immediately; no other cleanup.
//  FIFO: rd/wr pointers AW+1 bits with wrap bit.
//   - FULL when addresses are equal and wrap bits differ.
//   - Flags and LEVEL are registered and update the cycle after a push or pop.
//   - Push while FULL with no pop in the same cycle: byte dropped, OVERFLOW<=1.
//   - Push and pop in the same cycle: both occur and LEVEL is unchanged. This holds at FULL too.
//   - FLUSH: rd_ptr<=wr_ptr, LEVEL<=0. A WR_EN in the same cycle is discarded and does not set OVERFLOW.
//   - OVF_CLR wins over a same-cycle set.
//  busy_s/done_s: TX_BUSY/TX_DONE after SYNC_STAGES flops.
//  FSM:
//   - S_IDLE: if EN && !EMPTY && !busy_s && done_s:
//     - pop the head into TX_DIN, TX_START<=1, timer<=0, go to S_ARM.
//   - S_ARM: hold TX_START and TX_DIN; timer++.
//     - busy_s==1: TX_START<=0, go to S_SEND.
//     - timer==ARM_TIMEOUT-1: TX_START<=0, ARM_ERR<=1, go to S_IDLE. The byte is lost.
//   - S_SEND: TX_DIN held. When busy_s==0 && done_s==1, go to S_IDLE.
//  Timing and handshake rules:
//   - Back-to-back frames: the earliest next TX_START is 1 cycle after the return to S_IDLE.
//   - TX_DIN changes only on a pop, so it stays stable from TX_START until the frame ends.
//   - EN deassert: the current frame finishes and no new launch follows. FLUSH never aborts a frame.
//   - IDLE = EMPTY && state==S_IDLE (registered).
// STRUCTURE
//  Shared pkg ms_uart_pkg:
//   - state encoding localparams S_IDLE=2'd0, S_ARM=2'd1, S_SEND=2'd2.
//   - default DEPTH and ARM_TIMEOUT values.
//  Sub-module ms_uart_sync_fifo: parameterised DEPTH x 8 storage plus pointers, flags, LEVEL and FLUSH.
//  Top level: input synchronisers, launch FSM, timer and sticky flags.
// TESTING
//  1. Reset, 3 pushes (8'hA5, 8'h3C, 8'hFF), EN=1, transmitter model (BUSY 4 cycles after START, frame 40 cycles)
//     -> three TX_START pulses; TX_DIN=A5,3C,FF in order; LEVEL 3->2->1->0; IDLE=1 at end.
//  2. DEPTH=16, EN=0, 17 pushes -> FULL=1, LEVEL=16, OVERFLOW=1; 17th byte absent; OVF_CLR -> OVERFLOW=0.
//  3. FULL with EN=1: push and pop in the same cycle -> LEVEL stays 16; OVERFLOW stays 0.
//  4. Model never raises BUSY, ARM_TIMEOUT=20 -> TX_START high exactly 20 cycles; ARM_ERR=1; FSM back to S_IDLE.
//  5. FLUSH during S_SEND with LEVEL=5 -> LEVEL=0 next cycle; current frame completes; no further TX_START.
//  6. RESETN low mid-S_ARM -> TX_START=0 and TX_DIN=00 asynchronously; all outputs at reset values.

Source files
------------

// File: rtl/ms_uart_pkg.sv
// Shared definitions for the UART transmit feeder: launcher state encoding
// and default sizing.
package ms_uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_SEND = 2'd2
    } state_e;

    localparam int DEF_DEPTH       = 16;
    localparam int DEF_AW          = 4;
    localparam int DEF_ARM_TIMEOUT = 65535;

endpackage

// File: rtl/ms_uart_tx_feeder_if.sv
// Transmitter-side handshake between the feeder (master) and the UART
// transmitter (slave).
interface ms_uart_tx_feeder_if;
    logic       TX_START;
    logic [7:0] TX_DIN;
    logic       TX_BUSY;
    logic       TX_DONE;

    modport master (output TX_START, output TX_DIN, input TX_BUSY, input TX_DONE);
    modport slave  (input TX_START, input TX_DIN, output TX_BUSY, output TX_DONE);
endinterface

// File: rtl/ms_uart_sync_fifo.sv
// DEPTH x 8 byte FIFO with wrap-bit pointers, registered flags/level, flush,
// and a registered read port that only advances on a pop.
module ms_uart_sync_fifo
    import ms_uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          FLUSH,
    input  logic          WR_EN,
    input  logic [7:0]    WR_DATA,
    input  logic          RD_EN,
    output logic [7:0]    RD_DATA,
    output logic          FULL,
    output logic          EMPTY,
    output logic          EMPTY_NEXT,
    output logic [AW:0]   LEVEL,
    output logic          DROP
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] wr_ptr_next, rd_ptr_next;
    logic [AW:0] level_reg, level_next;
    logic        full_reg, full_next;
    logic        empty_reg, empty_next;
    logic [7:0]  rd_data_reg;
    logic        push, pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign pop  = RD_EN && !empty_reg && !FLUSH;
    assign push = WR_EN && !FLUSH && (!full_reg || pop);
    assign DROP = WR_EN && !FLUSH && full_reg && !pop;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + (AW+1)'(push);
        rd_ptr_next = FLUSH ? wr_ptr_reg : rd_ptr_reg + (AW+1)'(pop);
        level_next  = wr_ptr_next - rd_ptr_next;
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]) &&
                      (wr_ptr_next[AW] != rd_ptr_next[AW]);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            full_reg    <= 1'b0;
            empty_reg   <= 1'b1;
            rd_data_reg <= 8'h00;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
            if (pop)
                rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr_reg[AW-1:0]] <= WR_DATA;
    end

    assign RD_DATA    = rd_data_reg;
    assign FULL       = full_reg;
    assign EMPTY      = empty_reg;
    assign EMPTY_NEXT = empty_next;
    assign LEVEL      = level_reg;

endmodule

// File: rtl/ms_uart_tx_feeder.sv
// Byte buffer and launch sequencer in front of the UART transmitter: pops one
// byte per frame, raises START, and follows BUSY/DONE until the frame ends.
module ms_uart_tx_feeder
    import ms_uart_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = DEF_AW,
    parameter int SYNC_STAGES = 2,
    parameter int ARM_TIMEOUT = DEF_ARM_TIMEOUT
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 EN,
    input  logic                 FLUSH,
    input  logic                 WR_EN,
    input  logic [7:0]           WR_DATA,
    input  logic                 OVF_CLR,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic [AW:0]          LEVEL,
    output logic                 OVERFLOW,
    output logic                 ARM_ERR,
    output logic                 IDLE,
    ms_uart_tx_feeder_if.master  tx
);

    localparam int TW = $clog2(ARM_TIMEOUT + 1);

    state_e      state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic        start_reg, start_next;
    logic        overflow_reg, overflow_next;
    logic        arm_err_reg, arm_err_next;
    logic        idle_reg;
    logic        arm_err_set;
    logic        pop;
    logic        busy_s, done_s;
    logic        fifo_empty, fifo_empty_next, fifo_drop;

    ms_uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .FLUSH      (FLUSH),
        .WR_EN      (WR_EN),
        .WR_DATA    (WR_DATA),
        .RD_EN      (pop),
        .RD_DATA    (tx.TX_DIN),
        .FULL       (FULL),
        .EMPTY      (fifo_empty),
        .EMPTY_NEXT (fifo_empty_next),
        .LEVEL      (LEVEL),
        .DROP       (fifo_drop)
    );

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign busy_s = tx.TX_BUSY;
            assign done_s = tx.TX_DONE;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] busy_sync_reg, done_sync_reg;
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    busy_sync_reg <= '0;
                    done_sync_reg <= '0;
                end else begin
                    busy_sync_reg[0] <= tx.TX_BUSY;
                    done_sync_reg[0] <= tx.TX_DONE;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        busy_sync_reg[i] <= busy_sync_reg[i-1];
                        done_sync_reg[i] <= done_sync_reg[i-1];
                    end
                end
            end
            assign busy_s = busy_sync_reg[SYNC_STAGES-1];
            assign done_s = done_sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        start_next  = start_reg;
        pop         = 1'b0;
        arm_err_set = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // A flush in progress empties the FIFO, so no byte may leave with it.
                if (EN && !fifo_empty && !busy_s && done_s && !FLUSH) begin
                    pop        = 1'b1;
                    start_next = 1'b1;
                    timer_next = '0;
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                timer_next = timer_reg + 1'b1;
                if (busy_s) begin
                    start_next = 1'b0;
                    state_next = S_SEND;
                end else if (timer_reg == TW'(ARM_TIMEOUT - 1)) begin
                    start_next  = 1'b0;
                    arm_err_set = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_SEND: begin
                if (!busy_s && done_s)
                    state_next = S_IDLE;
            end
            default: begin
                start_next = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Clear has priority over a set arriving in the same cycle.
    assign overflow_next = OVF_CLR ? 1'b0 : (overflow_reg | fifo_drop);
    assign arm_err_next  = OVF_CLR ? 1'b0 : (arm_err_reg | arm_err_set);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg    <= S_IDLE;
            timer_reg    <= '0;
            start_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            arm_err_reg  <= 1'b0;
            idle_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            start_reg    <= start_next;
            overflow_reg <= overflow_next;
            arm_err_reg  <= arm_err_next;
            idle_reg     <= fifo_empty_next && (state_next == S_IDLE);
        end
    end

    assign tx.TX_START = start_reg;
    assign EMPTY       = fifo_empty;
    assign OVERFLOW    = overflow_reg;
    assign ARM_ERR     = arm_err_reg;
    assign IDLE        = idle_reg;

endmodule

// File: tb/tb_ms_uart_tx_feeder.sv
// Bench for ms_uart_tx_feeder: directed scenarios plus a random phase, checked
// against a queue-based model of the byte stream and sticky flags.
module tb_ms_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 20;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       EN = 1'b0, FLUSH = 1'b0, WR_EN = 1'b0, OVF_CLR = 1'b0;
    logic [7:0] WR_DATA = 8'h00;
    logic       FULL, EMPTY, OVERFLOW, ARM_ERR, IDLE;
    logic [AW:0] LEVEL;

    ms_uart_tx_feeder_if tx_if ();

    always #5 CLK = ~CLK;

    ms_uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .SYNC_STAGES (2),
        .ARM_TIMEOUT (TMO)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .EN       (EN),
        .FLUSH    (FLUSH),
        .WR_EN    (WR_EN),
        .WR_DATA  (WR_DATA),
        .OVF_CLR  (OVF_CLR),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .LEVEL    (LEVEL),
        .OVERFLOW (OVERFLOW),
        .ARM_ERR  (ARM_ERR),
        .IDLE     (IDLE),
        .tx       (tx_if.master)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         launches = 0;
    int         hi_cnt = 0;
    bit         busy_seen = 0, prev_start = 0, exp_ovf = 0, exp_arm = 0, ack_en = 0;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] q[$];

    // Transmitter: BUSY rises 4 cycles after START, frame lasts 40 cycles.
    initial begin
        tx_if.TX_BUSY = 1'b0;
        tx_if.TX_DONE = 1'b1;
        forever begin
            @(negedge CLK);
            if (ack_en && RESETN && tx_if.TX_START === 1'b1) begin
                repeat (4) @(negedge CLK);
                tx_if.TX_BUSY = 1'b1;
                tx_if.TX_DONE = 1'b0;
                repeat (40) @(negedge CLK);
                tx_if.TX_BUSY = 1'b0;
                tx_if.TX_DONE = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus followed by a model update and full output check.
    task automatic step(input bit wr, input logic [7:0] d, input bit fl, input bit clr);
        int size0;
        bit popped;
        WR_EN = wr; WR_DATA = d; FLUSH = fl; OVF_CLR = clr;
        @(posedge CLK);
        @(negedge CLK);
        size0  = q.size();
        popped = (tx_if.TX_START === 1'b1) && !prev_start;
        if (popped) begin
            chk("unexpected_start", 32'(size0 != 0), 32'd1);
            if (size0 != 0) begin
                cur_byte = q.pop_front();
                launches++;
                $display("launch %0d: byte %02h, %0d left", launches, cur_byte, q.size());
            end
            hi_cnt = 0;
            busy_seen = 0;
        end
        if (fl)
            q.delete();
        else if (wr) begin
            if (size0 < DEPTH || popped) q.push_back(d);
            else exp_ovf = 1;
        end
        if (tx_if.TX_START === 1'b1) begin
            hi_cnt++;
            if (tx_if.TX_BUSY) busy_seen = 1;
        end
        if (prev_start && tx_if.TX_START !== 1'b1 && !busy_seen) begin
            chk("arm_len", hi_cnt, TMO);
            exp_arm = 1;
        end
        if (clr) begin exp_ovf = 0; exp_arm = 0; end
        prev_start = (tx_if.TX_START === 1'b1);
        chk("level", LEVEL, q.size());
        chk("full", FULL, 32'(q.size() == DEPTH));
        chk("empty", EMPTY, 32'(q.size() == 0));
        chk("overflow", OVERFLOW, exp_ovf);
        chk("arm_err", ARM_ERR, exp_arm);
        chk("tx_din", tx_if.TX_DIN, cur_byte);
        WR_EN = 0; FLUSH = 0; OVF_CLR = 0;
    endtask

    task automatic wait_launch(input int target, input int bound, input string tag);
        int k = 0;
        while (launches < target && k < bound) begin step(0, 8'h00, 0, 0); k++; end
        chk(tag, launches, target);
    endtask

    task automatic wait_quiet(input int bound, input string tag);
        int k = 0;
        while (!(q.size() == 0 && tx_if.TX_START !== 1'b1 && tx_if.TX_BUSY !== 1'b1) && k < bound) begin
            step(0, 8'h00, 0, 0);
            k++;
        end
        chk(tag, 32'(k < bound), 32'd1);
        repeat (8) step(0, 8'h00, 0, 0);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_start"}, tx_if.TX_START, 0);
        chk({pfx, "_din"}, tx_if.TX_DIN, 0);
        chk({pfx, "_level"}, LEVEL, 0);
        chk({pfx, "_full"}, FULL, 0);
        chk({pfx, "_empty"}, EMPTY, 1);
        chk({pfx, "_ovf"}, OVERFLOW, 0);
        chk({pfx, "_armerr"}, ARM_ERR, 0);
        chk({pfx, "_idle"}, IDLE, 1);
    endtask

    initial begin
        int l0;
        repeat (3) @(negedge CLK);
        check_reset_values("rst");
        RESETN = 1'b1;

        // Three bytes sent in order
        ack_en = 1;
        step(1, 8'hA5, 0, 0);
        step(1, 8'h3C, 0, 0);
        step(1, 8'hFF, 0, 0);
        chk("t1_level3", LEVEL, 3);
        EN = 1;
        wait_quiet(400, "t1_drain");
        chk("t1_launches", launches, 3);
        chk("t1_idle", IDLE, 1);

        // Fill past capacity with launcher disabled
        EN = 0;
        for (int i = 0; i < DEPTH + 1; i++) step(1, 8'($urandom), 0, 0);
        chk("t2_full", FULL, 1);
        chk("t2_level", LEVEL, DEPTH);
        chk("t2_ovf", OVERFLOW, 1);
        step(0, 8'h00, 0, 1);
        chk("t2_ovf_clr", OVERFLOW, 0);

        // Push and pop together while full
        l0 = launches;
        EN = 1;
        step(1, 8'($urandom), 0, 0);
        chk("t3_pop", launches, l0 + 1);
        chk("t3_level", LEVEL, DEPTH);
        chk("t3_ovf", OVERFLOW, 0);
        wait_quiet(2000, "t3_drain");

        // Transmitter never acknowledges
        ack_en = 0;
        l0 = launches;
        step(1, 8'($urandom), 0, 0);
        wait_launch(l0 + 1, 10, "t4_launch");
        for (int k = 0; k < 40 && tx_if.TX_START === 1'b1; k++) step(0, 8'h00, 0, 0);
        chk("t4_start_low", tx_if.TX_START, 0);
        chk("t4_arm_err", ARM_ERR, 1);
        repeat (4) step(0, 8'h00, 0, 0);
        chk("t4_idle", IDLE, 1);
        step(0, 8'h00, 0, 1);
        chk("t4_clr", ARM_ERR, 0);
        ack_en = 1;

        // Random traffic with occasional flush and clear
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
        wait_quiet(1500, "rnd_drain");

        // Flush while a frame is on the wire
        EN = 0;
        for (int i = 0; i < 6; i++) step(1, 8'($urandom), 0, 0);
        l0 = launches;
        EN = 1;
        wait_launch(l0 + 1, 10, "t5_launch");
        for (int k = 0; k < 20 && tx_if.TX_BUSY !== 1'b1; k++) step(0, 8'h00, 0, 0);
        chk("t5_busy", tx_if.TX_BUSY, 1);
        repeat (4) step(0, 8'h00, 0, 0);
        chk("t5_level_pre", LEVEL, 5);
        step(0, 8'h00, 1, 0);
        chk("t5_level_post", LEVEL, 0);
        l0 = launches;
        wait_quiet(200, "t5_frame_end");
        repeat (50) step(0, 8'h00, 0, 0);
        chk("t5_no_restart", launches, l0);
        chk("t5_idle", IDLE, 1);

        // Reset while arming
        ack_en = 0;
        l0 = launches;
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0);
        wait_launch(l0 + 1, 10, "t6_launch");
        repeat (2) step(0, 8'h00, 0, 0);
        chk("t6_start_pre", tx_if.TX_START, 1);
        #2 RESETN = 1'b0;
        #1 check_reset_values("t6");
        @(negedge CLK);
        q.delete();
        cur_byte = 8'h00; exp_ovf = 0; exp_arm = 0; prev_start = 0; hi_cnt = 0;
        RESETN = 1'b1;
        repeat (4) step(0, 8'h00, 0, 0);
        chk("t6_idle_after", IDLE, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
